axi_stream_ts_pkt_arbiter: RTL

//  Packet-granular round-robin arbiter merging NUM_SRC timestamped packet streams (hdr/ts/data, tfirst/tlast framed)

---
 rtl/axi_stream_ts_pkt_arbiter_if.sv | 47 ++++
 rtl/axi_stream_ts_pkt_arbiter.sv | 130 +++++++++++++
 2 files changed

// File: rtl/axi_stream_ts_pkt_arbiter_if.sv
// Stream bundle between NUM_SRC packet sources and the merged output.
// slave is the arbiter's view; master is the view of whatever drives it.
interface axi_stream_ts_pkt_arbiter_if #(
  parameter int NUM_SRC = 4
);
  localparam int SRC_BITS = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [64*NUM_SRC-1:0] in_tdata;
  logic [NUM_SRC-1:0]    in_tfirst;
  logic [NUM_SRC-1:0]    in_tlast;
  logic [NUM_SRC-1:0]    in_tvalid;
  logic [NUM_SRC-1:0]    in_tready;
  logic [63:0]           out_tdata;
  logic                  out_tfirst;
  logic                  out_tlast;
  logic                  out_tvalid;
  logic                  out_tready;
  logic [SRC_BITS-1:0]   out_src;

  modport slave (
    input  in_tdata,
    input  in_tfirst,
    input  in_tlast,
    input  in_tvalid,
    output in_tready,
    output out_tdata,
    output out_tfirst,
    output out_tlast,
    output out_tvalid,
    input  out_tready,
    output out_src
  );

  modport master (
    output in_tdata,
    output in_tfirst,
    output in_tlast,
    output in_tvalid,
    input  in_tready,
    input  out_tdata,
    input  out_tfirst,
    input  out_tlast,
    input  out_tvalid,
    output out_tready,
    input  out_src
  );
endinterface

// File: rtl/axi_stream_ts_pkt_arbiter.sv
// Packet-granular round-robin merge of NUM_SRC framed 64-bit streams.
// Grant is locked per packet; output is a single register slice.
module axi_stream_ts_pkt_arbiter #(
  parameter int NUM_SRC     = 4,
  parameter int MAX_PKT_LEN = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] ch_ena,
  axi_stream_ts_pkt_arbiter_if.slave bus,
  output logic [31:0]        pkt_cnt,
  output logic               err_len,
  output logic               err_sync,
  input  logic               err_clr
);
  localparam int SRC_BITS = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_PKT  = 1'b1;

  localparam logic [16:0] LEN_LAST = 17'(MAX_PKT_LEN - 1);

  logic [0:0]          state;
  logic [SRC_BITS-1:0] grant;
  logic [SRC_BITS-1:0] last_grant;
  logic [SRC_BITS-1:0] nxt_grant;
  logic [16:0]         word_cnt;
  logic [NUM_SRC-1:0]  req;
  logic                found;
  int                  idx;

  logic        load;
  logic        cap;
  logic        sel_valid;
  logic        sel_first;
  logic        sel_last;
  logic [63:0] sel_data;
  logic        at_max;
  logic        pkt_end;
  logic        len_bad;
  logic        sync_bad;

  assign req  = bus.in_tvalid & ch_ena;
  assign load = ~bus.out_tvalid | bus.out_tready;

  always_comb begin
    sel_data      = '0;
    sel_first     = 1'b0;
    sel_last      = 1'b0;
    sel_valid     = 1'b0;
    bus.in_tready = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant == SRC_BITS'(i)) begin
        sel_data         = bus.in_tdata[64*i +: 64];
        sel_first        = bus.in_tfirst[i];
        sel_last         = bus.in_tlast[i];
        sel_valid        = bus.in_tvalid[i];
        bus.in_tready[i] = (state == ST_PKT) & load;
      end
    end
  end

  // Search starts one past the last packet's owner.
  always_comb begin
    nxt_grant = last_grant;
    found     = 1'b0;
    idx       = 0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      idx = (int'(last_grant) + k) % NUM_SRC;
      if (!found && req[idx]) begin
        nxt_grant = SRC_BITS'(idx);
        found     = 1'b1;
      end
    end
  end

  assign cap      = (state == ST_PKT) & load & sel_valid;
  assign at_max   = (word_cnt == LEN_LAST);
  assign pkt_end  = cap & (sel_last | at_max);
  assign len_bad  = cap & at_max & ~sel_last;
  assign sync_bad = cap & ((word_cnt == '0) ? ~sel_first
                                            : sel_first);

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      grant          <= '0;
      last_grant     <= SRC_BITS'(NUM_SRC - 1);
      word_cnt       <= '0;
      pkt_cnt        <= '0;
      err_len        <= 1'b0;
      err_sync       <= 1'b0;
      bus.out_tdata  <= '0;
      bus.out_tfirst <= 1'b0;
      bus.out_tlast  <= 1'b0;
      bus.out_tvalid <= 1'b0;
      bus.out_src    <= '0;
    end else begin
      if (cap) begin
        bus.out_tdata  <= sel_data;
        bus.out_tfirst <= sel_first;
        bus.out_tlast  <= sel_last | at_max;
        bus.out_tvalid <= 1'b1;
        bus.out_src    <= grant;
        word_cnt       <= word_cnt + 17'd1;
      end else if (bus.out_tready) begin
        bus.out_tvalid <= 1'b0;
      end

      if (pkt_end) begin
        pkt_cnt    <= pkt_cnt + 32'd1;
        last_grant <= grant;
        state      <= ST_IDLE;
      end

      if (state == ST_IDLE && |req) begin
        grant    <= nxt_grant;
        word_cnt <= '0;
        state    <= ST_PKT;
      end

      // A new fault outranks a coincident clear.
      if (len_bad)      err_len <= 1'b1;
      else if (err_clr) err_len <= 1'b0;

      if (sync_bad)     err_sync <= 1'b1;
      else if (err_clr) err_sync <= 1'b0;
    end
  end
endmodule
